// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input across fixed
// windows of GATE_CYCLES clk cycles. Each completed window publishes a result.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   rst        asynchronous, active-high reset
//   en         synchronous measurement enable; dropping it aborts the window
//   sig_in     signal under measurement (asynchronous to clk)
//   freq_out   edges counted in the last completed window (saturating)
//   valid      one-cycle strobe marking each freq_out update
//   overflow   last completed window lost edges to counter saturation
//   no_signal  last completed window counted zero edges
//
// Handshake: valid is a pure strobe with no ready. freq_out, overflow and
// no_signal change only in the cycle valid is high and hold otherwise; a
// consumer that misses the strobe can still read the held result.
//
// The FSM state is kept in state_q (IDLE/MEASURE) for checker binding.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             overflow,
  output logic             no_signal
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [31:0]      GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t state_q, state_d;

  // Synchronizer and edge detector: free-running in both states, so the
  // pulse latency (3 clk from sig_in rise) does not depend on en.
  logic sync_1, sync_2, sync_2_d, edge_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      sync_2_d   <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync_1     <= sig_in;
      sync_2     <= sync_1;
      sync_2_d   <= sync_2;
      edge_pulse <= sync_2 & ~sync_2_d;
    end
  end

  logic [31:0]      gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_d;
  logic             valid_d, overflow_d, no_signal_d;

  // Edge count including this cycle's pulse, clamped at CNT_MAX. An edge
  // arriving while already at CNT_MAX is a lost edge and marks overflow.
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_inc;
  logic             edge_lost;

  assign cnt_full  = (cnt_q == CNT_MAX);
  assign cnt_inc   = (edge_pulse && !cnt_full) ? cnt_q + 1'b1 : cnt_q;
  assign edge_lost = edge_pulse & cnt_full;

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    freq_d      = freq_out;
    overflow_d  = overflow;
    no_signal_d = no_signal;
    valid_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = MEASURE;
          gate_d  = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (!en) begin
          // Partial window is dropped; published results are untouched.
          state_d = IDLE;
        end else if (gate_q == GATE_LAST) begin
          // Terminal cycle: publish, and start the next window with no gap.
          // A pulse in this cycle belongs to the closing window.
          valid_d     = 1'b1;
          freq_d      = cnt_inc;
          overflow_d  = sat_q | edge_lost;
          no_signal_d = (cnt_inc == '0);
          gate_d      = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
        end else begin
          gate_d = gate_q + 32'd1;
          cnt_d  = cnt_inc;
          sat_d  = sat_q | edge_lost;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gate_q    <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      freq_out  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      freq_out  <= freq_d;
      valid     <= valid_d;
      overflow  <= overflow_d;
      no_signal <= no_signal_d;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter. dut_a (GATE_CYCLES=10, CNT_W=4) is checked every
// cycle against a window-level reference model; dut_b (GATE_CYCLES=100,
// CNT_W=4) is used for the saturation case.
module tb_freq_meter;

  localparam int G1   = 10;
  localparam int G2   = 100;
  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic en = 1'b0, sig_a = 1'b0;
  logic en2 = 1'b0, sig2 = 1'b0;

  logic [W-1:0] freq1, freq2;
  logic         valid1, ovf1, nos1;
  logic         valid2, ovf2, nos2;

  freq_meter #(.GATE_CYCLES(G1), .CNT_W(W)) dut_a (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_a),
    .freq_out(freq1), .valid(valid1), .overflow(ovf1), .no_signal(nos1)
  );

  freq_meter #(.GATE_CYCLES(G2), .CNT_W(W)) dut_b (
    .clk(clk), .rst(rst), .en(en2), .sig_in(sig2),
    .freq_out(freq2), .valid(valid2), .overflow(ovf2), .no_signal(nos2)
  );

  int errors = 0;
  int checks = 0;
  int tick   = 0;

  // ---------------- reference model ----------------
  // Sampled sig_in history (newest first). A rise sampled 3 edges ago is
  // the edge pulse counted at the current edge.
  logic         hist[$];
  bit           m_meas;
  int           m_pos;
  int           m_cnt;   // unbounded true edge count for the window
  logic [W-1:0] m_freq;
  logic         m_ovf, m_nos, m_valid;

  task automatic model_reset();
    m_meas  = 1'b0;
    m_pos   = 0;
    m_cnt   = 0;
    m_freq  = '0;
    m_ovf   = 1'b0;
    m_nos   = 1'b0;
    m_valid = 1'b0;
    hist.delete();
    for (int i = 0; i < 5; i++) hist.push_back(1'b0);
  endtask

  task automatic model_update();
    logic pulse;
    hist.push_front(sig_a);
    void'(hist.pop_back());
    pulse   = hist[3] & ~hist[4];
    m_valid = 1'b0;
    if (!m_meas) begin
      if (en) begin
        m_meas = 1'b1;
        m_pos  = 0;
        m_cnt  = 0;
      end
    end else if (!en) begin
      m_meas = 1'b0;
    end else begin
      m_cnt += int'(pulse);
      if (m_pos == G1 - 1) begin
        m_valid = 1'b1;
        m_freq  = W'((m_cnt > MAXV) ? MAXV : m_cnt);
        m_ovf   = (m_cnt > MAXV);
        m_nos   = (m_cnt == 0);
        m_cnt   = 0;
        m_pos   = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid",     32'(valid1), 32'(m_valid));
    chk("freq_out",  32'(freq1),  32'(m_freq));
    chk("overflow",  32'(ovf1),   32'(m_ovf));
    chk("no_signal", 32'(nos1),   32'(m_nos));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after an edge; outputs are sampled 1 time
  // unit after the following edge.
  task automatic step(input logic en_v, input logic sig_v);
    en    = en_v;
    sig_a = sig_v;
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    tick++;
    #1;
    check_outputs();
  endtask

  function automatic logic steady_sig();
    return logic'((tick >> 1) & 1);
  endfunction

  // Steps with en=1 and the period-4 signal until valid1; n = steps taken,
  // or -1 if the budget expired.
  task automatic count_to_valid(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step(1'b1, steady_sig());
      n++;
      if (valid1) return;
    end
    n = -1;
  endtask

  initial begin
    int vcount, n, nwin, last_v, prev_f, held_f;
    model_reset();

    // ---- reset with random inputs ----
    #2 rst = 1'b1;
    #1 check_outputs();
    for (int i = 0; i < 6; i++) step(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'(($urandom_range(0, 1))));
      vcount += int'(valid1);
    end
    chk("idle_valid_count", 32'(vcount), 32'd0);

    // ---- steady period-4 input ----
    for (int i = 0; i < 3; i++) step(1'b0, steady_sig());
    nwin = 0; last_v = 0; prev_f = -1;
    for (int i = 1; i <= 62; i++) begin
      step(1'b1, steady_sig());
      if (valid1) begin
        chk("steady_range", 32'(freq1 == 2 || freq1 == 3), 32'd1);
        if (prev_f >= 0) begin
          chk("steady_alt", 32'(int'(freq1) != prev_f), 32'd1);
          chk("steady_period", 32'(i - last_v), 32'(G1));
        end
        prev_f = int'(freq1);
        last_v = i;
        nwin++;
      end
    end
    chk("steady_windows", 32'(nwin), 32'd6);
    held_f = int'(m_freq);

    // ---- en abort at gate count 5 ----
    step(1'b0, steady_sig());
    step(1'b0, steady_sig());
    step(1'b1, steady_sig());
    for (int i = 0; i < 5; i++) step(1'b1, steady_sig());
    vcount = 0;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, steady_sig());
      vcount += int'(valid1);
    end
    chk("en_abort_valid", 32'(vcount), 32'd0);
    chk("en_abort_hold", 32'(freq1), 32'(held_f));
    step(1'b1, steady_sig());
    count_to_valid(30, n);
    chk("en_reenable_latency", 32'(n), 32'(G1));

    // ---- reset abort mid-window ----
    for (int i = 0; i < 4; i++) step(1'b1, steady_sig());
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    chk("rst_abort_freq", 32'(freq1), 32'd0);
    step(1'b1, steady_sig());
    rst = 1'b0;
    step(1'b1, steady_sig());
    count_to_valid(30, n);
    chk("rst_reenable_latency", 32'(n), 32'(G1));

    // ---- en falls on the terminal cycle ----
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("term_en_drop_valid", 32'(valid1), 32'd0);

    // ---- edge pulse on the terminal cycle, then held-high input ----
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) step(1'b1, logic'(k >= 7));
    chk("term_edge_valid", 32'(valid1), 32'd1);
    chk("term_edge_freq", 32'(freq1), 32'd1);
    for (int k = 1; k <= 10; k++) step(1'b1, 1'b1);
    chk("next_win_valid", 32'(valid1), 32'd1);
    chk("next_win_freq", 32'(freq1), 32'd0);
    chk("next_win_nosig", 32'(nos1), 32'd1);
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1);
      if (valid1) begin
        vcount++;
        chk("nosig_flag", 32'(nos1), 32'd1);
      end
    end
    chk("nosig_windows", 32'(vcount), 32'd2);

    // ---- saturation on the 100-cycle instance ----
    step(1'b0, 1'b0);
    en2 = 1'b1;
    n = -1;
    for (int k = 1; k <= 250; k++) begin
      sig2 = ~sig2;
      step(1'b0, 1'b0);
      if (valid2) begin
        n = k;
        break;
      end
    end
    chk("sat_first_valid_found", 32'(n > 0), 32'd1);
    chk("sat_freq", 32'(freq2), 32'(MAXV));
    chk("sat_overflow", 32'(ovf2), 32'd1);
    chk("sat_nosig", 32'(nos2), 32'd0);
    n = -1;
    for (int k = 1; k <= 150; k++) begin
      sig2 = ~sig2;
      step(1'b0, 1'b0);
      if (valid2) begin
        n = k;
        break;
      end
    end
    chk("sat_period", 32'(n), 32'(G2));
    chk("sat_freq_2", 32'(freq2), 32'(MAXV));
    en2 = 1'b0;

    // ---- randomized traffic against the model ----
    begin
      logic en_r, sig_r;
      en_r = 1'b1;
      sig_r = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (en_r) en_r = ($urandom_range(0, 29) != 0);
        else      en_r = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 3) == 0) sig_r = ~sig_r;
        if ((i / 100) % 2 == 1) sig_r = 1'(($urandom_range(0, 1)));
        step(en_r, sig_r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
